raptor64_regwrite_ctrl: RTL and testbench

- Write-side controller for the Raptor64 register file. It merges two result sources into the single register-file write port and into the trailer (T) bypass register: the in-order pipeline result from the M2 stage, and late results from the multi-cycle unit (mul/div).
- It drives wIRvalid/wRt/wData and tRt/tData, which the read-side bypass muxes consume.
- Multi-cycle results wait in a 2-entry buffer and are written only in cycles the pipeline leaves the write slot free.

---
 rtl/raptor64_pkg.sv | 22 ++
 rtl/raptor64_wb_fifo.sv | 83 ++++++++
 rtl/raptor64_regwrite_ctrl.sv | 89 ++++++++
 tb/tb_raptor64_regwrite_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/raptor64_pkg.sv
// Shared Raptor64 write-back definitions: widths, special registers, entry type.
package raptor64_pkg;

    localparam int AW_DEF = 9;
    localparam int DW_DEF = 64;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_PC   = 5'd29;

    // Multi-cycle result buffer entry at default widths.
    typedef struct packed {
        logic              valid;
        logic [AW_DEF-1:0] rt;
        logic [DW_DEF-1:0] data;
    } wb_entry_t;

    // r0 and the pc alias decode only on the low five address bits.
    function automatic logic writable(input logic [4:0] rt5);
        return (rt5 != REG_ZERO) && (rt5 != REG_PC);
    endfunction

endpackage

// File: rtl/raptor64_wb_fifo.sv
// Multi-cycle result FIFO with per-entry kill by Rt match and Rt lookup.
module raptor64_wb_fifo
    import raptor64_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [AW-1:0] push_rt,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic          kill_en,
    input  logic [AW-1:0] kill_rt,
    input  logic [AW-1:0] q_rt,
    output logic          q_hit,
    output logic          ready,
    output logic          nonempty,
    output logic          head_live,
    output logic [AW-1:0] head_rt,
    output logic [DW-1:0] head_data
);

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rt;
        logic [DW-1:0] data;
    } entry_t;

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    entry_t        mem [DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;

    assign ready     = (count < FULL);
    assign nonempty  = (count != '0);
    assign head_live = mem[head].valid;
    assign head_rt   = mem[head].rt;
    assign head_data = mem[head].data;

    // Lookup sees only registered state; a same-cycle push is not visible.
    always_comb begin
        q_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (mem[i].valid && (mem[i].rt == q_rt)) q_hit = 1'b1;
    end

    // Entry storage: kill older matches, retire head, append tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (kill_en && mem[i].valid && (mem[i].rt == kill_rt))
                    mem[i].valid <= 1'b0;
            if (pop)  mem[head].valid <= 1'b0;
            if (push) mem[tail] <= '{valid: 1'b1, rt: push_rt, data: push_data};
        end
    end

    // Pointers wrap naturally at PW bits; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop)  head <= head + 1'b1;
            if (push) tail <= tail + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/raptor64_regwrite_ctrl.sv
// Register-file write port and trailer arbitration between M2 and the multi-cycle unit.
module raptor64_regwrite_ctrl
    import raptor64_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          advanceW,
    input  logic          m2IRvalid,
    input  logic [AW-1:0] m2Rt,
    input  logic [DW-1:0] m2Data,
    input  logic          mc_valid,
    input  logic [AW-1:0] mc_Rt,
    input  logic [DW-1:0] mc_data,
    output logic          mc_ready,
    input  logic [AW-1:0] q_rt,
    output logic          q_hit,
    output logic          wIRvalid,
    output logic [AW-1:0] wRt,
    output logic [DW-1:0] wData,
    output logic [AW-1:0] tRt,
    output logic [DW-1:0] tData
);

    logic          slot_taken, push, pop;
    logic          nonempty, head_live;
    logic [AW-1:0] head_rt;
    logic [DW-1:0] head_data;

    // Pipeline owns the write slot; buffer drains only into an idle slot.
    // Offers to r0/pc complete the handshake but are never stored.
    always_comb begin
        slot_taken = advanceW && m2IRvalid && writable(m2Rt[4:0]);
        push       = mc_valid && mc_ready && writable(mc_Rt[4:0]);
        pop        = !slot_taken && nonempty;
    end

    raptor64_wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_rt   (mc_Rt),
        .push_data (mc_data),
        .pop       (pop),
        .kill_en   (slot_taken),
        .kill_rt   (m2Rt),
        .q_rt      (q_rt),
        .q_hit     (q_hit),
        .ready     (mc_ready),
        .nonempty  (nonempty),
        .head_live (head_live),
        .head_rt   (head_rt),
        .head_data (head_data)
    );

    // W-stage write register; a killed head is popped without writing.
    always_ff @(posedge clk) begin
        if (rst) begin
            wIRvalid <= 1'b0;
            wRt      <= '0;
            wData    <= '0;
        end else if (slot_taken) begin
            wIRvalid <= 1'b1;
            wRt      <= m2Rt;
            wData    <= m2Data;
        end else if (pop && head_live) begin
            wIRvalid <= 1'b1;
            wRt      <= head_rt;
            wData    <= head_data;
        end else begin
            wIRvalid <= 1'b0;
        end
    end

    // Trailer keeps the most recent completed write for the bypass muxes.
    always_ff @(posedge clk) begin
        if (rst) begin
            tRt   <= '0;
            tData <= '0;
        end else if (wIRvalid) begin
            tRt   <= wRt;
            tData <= wData;
        end
    end

endmodule

// File: tb/tb_raptor64_regwrite_ctrl.sv
// Directed checks for raptor64_regwrite_ctrl.
module tb_raptor64_regwrite_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        advanceW, m2IRvalid, mc_valid;
    logic [8:0]  m2Rt, mc_Rt, q_rt;
    logic [63:0] m2Data, mc_data;
    logic        mc_ready, q_hit, wIRvalid;
    logic [8:0]  wRt, tRt;
    logic [63:0] wData, tData;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    raptor64_regwrite_ctrl dut (
        .clk(clk), .rst(rst),
        .advanceW(advanceW), .m2IRvalid(m2IRvalid), .m2Rt(m2Rt), .m2Data(m2Data),
        .mc_valid(mc_valid), .mc_Rt(mc_Rt), .mc_data(mc_data), .mc_ready(mc_ready),
        .q_rt(q_rt), .q_hit(q_hit),
        .wIRvalid(wIRvalid), .wRt(wRt), .wData(wData),
        .tRt(tRt), .tData(tData)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe(input logic v, input logic [8:0] rt, input logic [63:0] d);
        advanceW = v; m2IRvalid = v; m2Rt = rt; m2Data = d;
    endtask

    task automatic offer(input logic v, input logic [8:0] rt, input logic [63:0] d);
        mc_valid = v; mc_Rt = rt; mc_data = d;
    endtask

    initial begin
        rst = 1'b1; q_rt = '0;
        pipe(0, 0, 0); offer(0, 0, 0);
        tick(); tick();
        rst = 1'b0;
        chk("rst_wv", wIRvalid, 0);
        chk("rst_wrt", wRt, 0);
        chk("rst_wdata", wData, 0);
        chk("rst_trt", tRt, 0);
        chk("rst_tdata", tData, 0);
        chk("rst_ready", mc_ready, 1);
        chk("rst_qhit", q_hit, 0);

        // plain pipeline write, then trailer follows one cycle later
        pipe(1, 9'd5, 64'hAA);
        tick();
        chk("p_wv", wIRvalid, 1);
        chk("p_wrt", wRt, 5);
        chk("p_wdata", wData, 64'hAA);
        pipe(0, 0, 0);
        tick();
        chk("p_trt", tRt, 5);
        chk("p_tdata", tData, 64'hAA);
        chk("p_idle_wv", wIRvalid, 0);
        chk("p_hold_wrt", wRt, 5);

        // r0 / pc alias never written or buffered
        pipe(1, 9'h020, 64'h11);
        tick();
        chk("r0_wv", wIRvalid, 0);
        pipe(1, 9'd29, 64'h22);
        tick();
        chk("pc_wv", wIRvalid, 0);
        pipe(0, 0, 0);
        offer(1, 9'd0, 64'h33);
        #1 chk("mc0_ready_pre", mc_ready, 1);
        tick();
        offer(0, 0, 0);
        chk("mc0_ready", mc_ready, 1);
        q_rt = 9'd0;
        #1 chk("mc0_qhit", q_hit, 0);
        tick();
        chk("mc0_wv", wIRvalid, 0);
        chk("mc0_trt", tRt, 5);

        // fill the buffer under a busy pipeline
        pipe(1, 9'd20, 64'h200); offer(1, 9'd7, 64'h70);
        #1 chk("fill_rdy1", mc_ready, 1);
        tick();
        pipe(1, 9'd21, 64'h210); offer(1, 9'd8, 64'h80);
        #1 chk("fill_rdy2", mc_ready, 1);
        tick();
        pipe(1, 9'd22, 64'h220); offer(1, 9'd9, 64'h90);
        #1 chk("fill_rdy3", mc_ready, 0);
        tick();
        chk("fill_prio_wrt", wRt, 22);
        chk("fill_prio_wdata", wData, 64'h220);
        pipe(0, 0, 0);
        q_rt = 9'd7;
        #1 chk("fill_qhit7", q_hit, 1);
        chk("fill_rdy4", mc_ready, 0);
        tick();
        chk("drain7_wv", wIRvalid, 1);
        chk("drain7_wrt", wRt, 7);
        chk("drain7_wdata", wData, 64'h70);
        chk("drain7_rdy", mc_ready, 1);
        tick();
        offer(0, 0, 0);
        chk("drain8_wv", wIRvalid, 1);
        chk("drain8_wrt", wRt, 8);
        chk("drain8_wdata", wData, 64'h80);
        tick();
        chk("drain9_wv", wIRvalid, 1);
        chk("drain9_wrt", wRt, 9);
        chk("drain9_wdata", wData, 64'h90);
        tick();
        chk("drain_done_wv", wIRvalid, 0);
        chk("drain_done_rdy", mc_ready, 1);

        // WAW kill: younger pipeline write to the same Rt
        offer(1, 9'd12, 64'h1);
        tick();
        offer(0, 0, 0);
        q_rt = 9'd12;
        #1 chk("waw_qhit_pre", q_hit, 1);
        pipe(1, 9'd12, 64'h2);
        tick();
        pipe(0, 0, 0);
        chk("waw_wv", wIRvalid, 1);
        chk("waw_wdata", wData, 64'h2);
        chk("waw_qhit_post", q_hit, 0);
        tick();
        chk("waw_pop_wv", wIRvalid, 0);
        tick();
        chk("waw_after_wv", wIRvalid, 0);
        chk("waw_after_wdata", wData, 64'h2);

        // same-cycle enqueue is older than nothing: it survives and writes later
        pipe(1, 9'd14, 64'h4); offer(1, 9'd14, 64'h3);
        tick();
        pipe(0, 0, 0); offer(0, 0, 0);
        q_rt = 9'd14;
        chk("same_wdata", wData, 64'h4);
        #1 chk("same_qhit", q_hit, 1);
        tick();
        chk("same_drain_wv", wIRvalid, 1);
        chk("same_drain_wdata", wData, 64'h3);
        tick();

        // reset mid-stream discards buffered work
        pipe(1, 9'd16, 64'h160); offer(1, 9'd15, 64'h5);
        tick();
        pipe(0, 0, 0); offer(1, 9'd17, 64'h6);
        rst = 1'b1;
        tick();
        offer(0, 0, 0);
        chk("mrst_wv", wIRvalid, 0);
        chk("mrst_trt", tRt, 0);
        chk("mrst_ready", mc_ready, 1);
        q_rt = 9'd15;
        #1 chk("mrst_qhit15", q_hit, 0);
        q_rt = 9'd17;
        #1 chk("mrst_qhit17", q_hit, 0);
        rst = 1'b0;
        tick();
        chk("mrst_post_wv", wIRvalid, 0);
        tick();
        chk("mrst_post2_wv", wIRvalid, 0);
        chk("mrst_post_wdata", wData, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
